// File: rtl/mux4_sel_pkg.sv
// Shared definitions for the 4:1 mux select arbiter family.
//   state_t          : arbiter FSM states
//   NREQ / SEL_W     : requester count and matching select width
//   DEFAULT_MAX_HOLD : default grant hold limit in cycles
package mux4_sel_pkg;

  localparam int NREQ             = 4;
  localparam int SEL_W            = $clog2(NREQ);
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr,
// wrapping around.
//   req   : request vector
//   ptr   : index where the search starts
//   found : at least one request bit is set
//   idx   : index of the chosen requester (0 when found is low)
module rr_priority_pick #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [SEL_W-1:0]  off;

  always_comb begin
    // Rotating the doubled vector right by ptr puts requester ptr at bit 0.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    found   = 1'b0;
    off     = '0;
    // Scan downward so the last hit kept is the lowest set bit.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    idx = SEL_W'((int'(off) + int'(ptr)) % NREQ);
  end

endmodule

// File: rtl/mux4_rr_selector.sv
// Round-robin arbiter driving the select of the 4:1 mux.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : per-requester request level
//   done    : current owner releases the grant
//   sel     : granted index, to mux sel (holds its value after release)
//   grant   : one-hot grant, zero when idle
//   valid   : a grant is active, mux output is qualified
//   timeout : one-cycle pulse when the hold limit alone revokes a grant
//
// state | meaning
// IDLE  | no owner; pick next requester from ptr with wrap
// GRANT | owner holds the mux until done, request drop or hold limit
module mux4_rr_selector #(
  parameter int NREQ     = mux4_sel_pkg::NREQ,
  parameter int SEL_W    = mux4_sel_pkg::SEL_W,
  parameter int MAX_HOLD = mux4_sel_pkg::DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic             valid,
  output logic             timeout
);

  import mux4_sel_pkg::*;

  localparam int CNT_W = 8;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [NREQ-1:0]  grant_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_limit;
  logic             rel_any;

  rr_priority_pick #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      grant   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sel     <= sel_nxt;
      grant   <= grant_nxt;
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    grant_nxt   = grant;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt;

    owner_req  = req[sel];
    hold_limit = (cnt == CNT_W'(MAX_HOLD - 1));
    rel_any    = done | ~owner_req | hold_limit;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        grant_nxt = '0;
        if (pick_found) begin
          state_nxt           = GRANT;
          sel_nxt             = pick_idx;
          grant_nxt[pick_idx] = 1'b1;
          valid_nxt           = 1'b1;
          cnt_nxt             = '0;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 1'b1;
        if (rel_any) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          valid_nxt   = 1'b0;
          cnt_nxt     = '0;
          ptr_nxt     = SEL_W'((int'(sel) + 1) % NREQ);
          // A done or a dropped request on the same cycle makes this an
          // ordinary release, not a revocation.
          timeout_nxt = hold_limit & ~done & owner_req;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_selector.sv
module tb_mux4_rr_selector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mux4_rr_selector #(
    .NREQ     (4),
    .SEL_W    (2),
    .MAX_HOLD (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 20);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sel, grant, valid, timeout} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got sel=%0d grant=%b valid=%b timeout=%b exp all zero",
               sel, grant, valid, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (sel !== 2'd2 || grant !== 4'b0100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL single_first_grant got sel=%0d grant=%b valid=%b exp sel=2 grant=0100 valid=1",
               sel, grant, valid);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b1) break;
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL single_hold_len got %0d exp 8", n);
    end
    checks++;
    if (timeout !== 1'b1 || grant !== 4'b0000 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_timeout got timeout=%b grant=%b sel=%0d exp timeout=1 grant=0000 sel=2",
               timeout, grant, sel);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd2 || timeout !== 1'b0 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_regrant got valid=%b sel=%0d timeout=%b grant=%b exp valid=1 sel=2 timeout=0 grant=0100",
               valid, sel, timeout, grant);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got valid=%b timeout=%b exp 0 0", valid, timeout);
    end
  endtask

  task automatic test_rotation();
    int n;
    logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_valid(n);
      checks++;
      if (valid !== 1'b1 || n !== 1 || sel !== exp_sel[g] || grant !== (4'b0001 << exp_sel[g])) begin
        errors++;
        $display("FAIL rotation_grant%0d got valid=%b wait=%0d sel=%0d grant=%b exp valid=1 wait=1 sel=%0d",
                 g, valid, n, sel, grant, exp_sel[g]);
      end
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checks++;
      if (valid !== 1'b0 || timeout !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL rotation_release%0d got valid=%b timeout=%b grant=%b exp 0 0 0000",
                 g, valid, timeout, grant);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    req = 4'b1000;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd3) begin
      errors++;
      $display("FAIL wrap_first got valid=%b sel=%0d exp 1 3", valid, sel);
    end
    req = 4'b0011;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || n !== 2 || sel !== 2'd0) begin
      errors++;
      $display("FAIL wrap_sel0 got valid=%b wait=%0d sel=%0d exp 1 2 0", valid, n, sel);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || n !== 1 || sel !== 2'd1 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_sel1 got valid=%b wait=%0d sel=%0d grant=%b exp 1 1 1 0010",
               valid, n, sel, grant);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    req = 4'b0110;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd1) begin
      errors++;
      $display("FAIL drop_first got valid=%b sel=%0d exp 1 1", valid, sel);
    end
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release got valid=%b timeout=%b exp 0 0", valid, timeout);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd2 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL drop_next got valid=%b sel=%0d grant=%b exp 1 2 0100", valid, sel, grant);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_done_limit();
    int n;
    do_reset();
    req = 4'b0001;
    wait_valid(n);
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd0) begin
      errors++;
      $display("FAIL limit_cycle8 got valid=%b sel=%0d exp 1 0", valid, sel);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL limit_done_release got valid=%b timeout=%b exp 0 0", valid, timeout);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    req = 4'b1000;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || sel !== 2'd3) begin
      errors++;
      $display("FAIL areset_pre got valid=%b sel=%0d exp 1 3", valid, sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sel !== 2'd0 || grant !== 4'b0000 || valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got sel=%0d grant=%b valid=%b timeout=%b exp 0 0000 0 0",
               sel, grant, valid, timeout);
    end
    req = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    wait_valid(n);
    checks++;
    if (valid !== 1'b1 || n !== 1 || sel !== 2'd1 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL areset_regrant got valid=%b wait=%0d sel=%0d grant=%b exp 1 1 1 0010",
               valid, n, sel, grant);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_drop();
    test_done_limit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
